// File: rtl/nested_loop_counter.sv
// Multi-level nested loop counter: per-level index plus accumulated linear address for PE address generation.
// Latency: start sampled in IDLE gives the first live iteration the next cycle; one iteration per cycle after that.
// Backpressure: stall holds index/addr/valid; an iteration advances only when valid=1 and stall=0 at posedge.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   cfg_we/cfg_level/cfg_bound/cfg_stride   per-level bound and stride write (IDLE only)
//   start, stall              sweep launch (IDLE only); consumer back-pressure
//   busy, valid, index, addr  sweep status and current iteration
//   done                      one-cycle pulse after the final iteration is accepted
//   last                      per-level "at final value" flags
// Build option: define LOOP_LAST_FLAGS_EN to drive last[]; otherwise last is tied to 0.
module nested_loop_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LEVELS = 3,
    parameter int ADDR_WIDTH = 16,
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [LVL_W-1:0]                 cfg_level,
    input  logic [DATA_WIDTH-1:0]            cfg_bound,
    input  logic [DATA_WIDTH-1:0]            cfg_stride,
    input  logic                             start,
    input  logic                             stall,
    output logic                             busy,
    output logic                             valid,
    output logic [NUM_LEVELS*DATA_WIDTH-1:0] index,
    output logic [ADDR_WIDTH-1:0]            addr,
    output logic                             done,
    output logic [NUM_LEVELS-1:0]            last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] bound_q  [NUM_LEVELS];
    logic [DATA_WIDTH-1:0] stride_q [NUM_LEVELS];
    logic [DATA_WIDTH-1:0] idx_q    [NUM_LEVELS];
    logic [ADDR_WIDTH-1:0] off_q    [NUM_LEVELS];
    logic [DATA_WIDTH-1:0] fin_val  [NUM_LEVELS];

    logic [NUM_LEVELS-1:0] at_final;
    logic [NUM_LEVELS-1:0] step;
    logic                  carry;
    logic                  all_final;
    logic                  run;
    logic                  accept;
    logic                  last_accept;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] addr_sum;

    assign run         = (state == RUN);
    assign accept      = run & ~stall;
    assign last_accept = accept & all_final;

    // A programmed bound of 0 behaves as 1, so its final index is 0 either way.
    always_comb begin
        for (int k = 0; k < NUM_LEVELS; k++) begin
            fin_val[k]  = (bound_q[k] == '0) ? '0 : bound_q[k] - 1'b1;
            at_final[k] = (idx_q[k] == fin_val[k]);
        end
    end

    // Ripple carry: a level steps when every inner level is at its final value.
    always_comb begin
        carry = 1'b1;
        step  = '0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            step[k] = carry;
            carry   = carry & at_final[k];
        end
        all_final = carry;
    end

    always_comb begin
        addr_sum = '0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            addr_sum = addr_sum + off_q[k];
        end
    end

    always_comb begin
        index = '0;
        if (run) begin
            for (int k = 0; k < NUM_LEVELS; k++) begin
                index[k*DATA_WIDTH +: DATA_WIDTH] = idx_q[k];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
            for (int k = 0; k < NUM_LEVELS; k++) begin
                bound_q[k]  <= DATA_WIDTH'(1);
                stride_q[k] <= '0;
                idx_q[k]    <= '0;
                off_q[k]    <= '0;
            end
        end else begin
            state  <= state_nxt;
            done_q <= last_accept;
            if (state == IDLE) begin
                // Config write and sweep clear may share an edge; the sweep sees the new config.
                if (cfg_we && (int'(cfg_level) < NUM_LEVELS)) begin
                    bound_q[cfg_level]  <= cfg_bound;
                    stride_q[cfg_level] <= cfg_stride;
                end
                if (start) begin
                    for (int k = 0; k < NUM_LEVELS; k++) begin
                        idx_q[k] <= '0;
                        off_q[k] <= '0;
                    end
                end
            end else if (accept) begin
                // On the final iteration every level wraps, leaving all counters clear for IDLE.
                for (int k = 0; k < NUM_LEVELS; k++) begin
                    if (step[k]) begin
                        if (at_final[k]) begin
                            idx_q[k] <= '0;
                            off_q[k] <= '0;
                        end else begin
                            idx_q[k] <= idx_q[k] + 1'b1;
                            off_q[k] <= off_q[k] + ADDR_WIDTH'(stride_q[k]);
                        end
                    end
                end
            end
        end
    end

    assign valid = run;
    assign busy  = run;
    assign addr  = run ? addr_sum : '0;
    assign done  = done_q;

`ifdef LOOP_LAST_FLAGS_EN
    assign last = run ? at_final : '0;
`else
    assign last = '0;
`endif

endmodule

// File: tb/tb_nested_loop_counter.sv
module tb_nested_loop_counter;

    localparam int DW = 8;
    localparam int NL = 3;
    localparam int AW = 9;
    localparam int LW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [LW-1:0]   cfg_level;
    logic [DW-1:0]   cfg_bound;
    logic [DW-1:0]   cfg_stride;
    logic            start;
    logic            stall;
    logic            busy;
    logic            valid;
    logic [NL*DW-1:0] index;
    logic [AW-1:0]   addr;
    logic            done;
    logic [NL-1:0]   last;

    nested_loop_counter #(
        .DATA_WIDTH(DW),
        .NUM_LEVELS(NL),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_level (cfg_level),
        .cfg_bound (cfg_bound),
        .cfg_stride(cfg_stride),
        .start     (start),
        .stall     (stall),
        .busy      (busy),
        .valid     (valid),
        .index     (index),
        .addr      (addr),
        .done      (done),
        .last      (last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL*DW-1:0] idx;
        logic [AW-1:0]    addr;
        logic [NL-1:0]    lst;
        bit               fin;
    } beat_t;

    beat_t sb[$];
    int    checks    = 0;
    int    failures  = 0;
    int    timeouts  = 0;
    bit    mon_en    = 1'b0;
    bit    fin_req   = 1'b0;
    bit    exp_done  = 1'b0;
    bit    exp_valid = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: compares the presented iteration with the scoreboard head every cycle,
    // popping it only when the beat is consumed (valid and not stalled).
    always @(negedge clk) begin
        beat_t         it;
        logic [NL-1:0] elst;
        if (mon_en) begin
            chk("done", 32'(done), 32'(exp_done));
            if (exp_valid) chk("start_latency_valid", 32'(valid), 32'd1);
            exp_done  = 1'b0;
            exp_valid = !valid && start && rst;
            if (valid) begin
                chk("busy_run", 32'(busy), 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat got index=0x%0h addr=%0d expected no beat", index, addr);
                end else begin
                    it = sb[0];
`ifdef LOOP_LAST_FLAGS_EN
                    elst = it.lst;
`else
                    elst = '0;
`endif
                    chk("index", 32'(index), 32'(it.idx));
                    chk("addr", 32'(addr), 32'(it.addr));
                    chk("last", 32'(last), 32'(elst));
                    if (!stall) begin
                        void'(sb.pop_front());
                        exp_done = it.fin && rst;
                    end
                end
            end else begin
                chk("busy_idle", 32'(busy), 32'd0);
                chk("index_idle", 32'(index), 32'd0);
                chk("addr_idle", 32'(addr), 32'd0);
                chk("last_idle", 32'(last), 32'd0);
            end
            if (fin_req) begin
                chk("scoreboard_drained", 32'(sb.size()), 32'd0);
                chk("sweep_timeouts", 32'(timeouts), 32'd0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i2, input int i1, input int i0, input int a,
                        input logic [NL-1:0] l, input bit f);
        beat_t b;
        b.idx  = {DW'(i2), DW'(i1), DW'(i0)};
        b.addr = AW'(a);
        b.lst  = l;
        b.fin  = f;
        sb.push_back(b);
    endtask

    // Bounds {2,3,1}, strides {1,4,0}: hand-computed beats.
    task automatic push_basic(input int n);
        int            a_t[6] = '{0, 1, 4, 5, 8, 9};
        logic [NL-1:0] l_t[6] = '{3'b100, 3'b101, 3'b100, 3'b101, 3'b110, 3'b111};
        for (int b = 0; b < n; b++) begin
            push(0, b / 2, b % 2, a_t[b], l_t[b], b == 5);
        end
    endtask

    task automatic cfg(input int l, input int bnd, input int str);
        cfg_we     = 1'b1;
        cfg_level  = LW'(l);
        cfg_bound  = DW'(bnd);
        cfg_stride = DW'(str);
        step_cycle();
        cfg_we     = 1'b0;
    endtask

    task automatic cfg_basic();
        cfg(0, 2, 1);
        cfg(1, 3, 4);
        cfg(2, 1, 0);
    endtask

    // kind: 0 plain, 1 stall cycles 4-6, 2 cfg_we+start in cycle 2,
    //       3 reset during cycle 3, 4 start during the done cycle (7).
    task automatic sweep(input bit do_start, input int kind);
        int c    = 1;
        bit seen = 1'b0;
        if (do_start) begin
            start = 1'b1;
            step_cycle();
        end
        while (!seen && c <= 100) begin
            stall  = (kind == 1) && (c >= 4) && (c <= 6);
            cfg_we = (kind == 2) && (c == 2);
            if (kind == 2 && c == 2) begin
                cfg_level  = '0;
                cfg_bound  = DW'(5);
                cfg_stride = DW'(9);
            end
            start = ((kind == 2) && (c == 2)) || ((kind == 4) && (c == 7));
            rst   = !((kind == 3) && (c == 3));
            @(negedge clk);
            seen = (done == 1'b1) || ((kind == 3) && (c == 4));
            step_cycle();
            c++;
        end
        stall  = 1'b0;
        cfg_we = 1'b0;
        start  = 1'b0;
        rst    = 1'b1;
        if (!seen) timeouts++;
    endtask

    initial begin
        rst        = 1'b0;
        cfg_we     = 1'b0;
        cfg_level  = '0;
        cfg_bound  = '0;
        cfg_stride = '0;
        start      = 1'b0;
        stall      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        step_cycle();

        cfg_basic();
        push_basic(6);
        sweep(1'b1, 0);

        push_basic(6);
        sweep(1'b1, 1);

        push_basic(6);
        push_basic(6);
        sweep(1'b1, 4);
        sweep(1'b0, 0);

        push_basic(6);
        sweep(1'b1, 2);
        push_basic(6);
        sweep(1'b1, 0);

        // Bound 0 on L0 and address wrap at 2^9; the L1 write shares the start edge.
        cfg(0, 0, 7);
        cfg(2, 1, 0);
        push(0, 0, 0, 0,   3'b101, 1'b0);
        push(0, 1, 0, 200, 3'b101, 1'b0);
        push(0, 2, 0, 400, 3'b101, 1'b0);
        push(0, 3, 0, 88,  3'b111, 1'b1);
        cfg_we     = 1'b1;
        cfg_level  = LW'(1);
        cfg_bound  = DW'(4);
        cfg_stride = DW'(200);
        sweep(1'b1, 0);

        cfg_basic();
        push_basic(3);
        sweep(1'b1, 3);
        push(0, 0, 0, 0, 3'b111, 1'b1);
        sweep(1'b1, 0);

        repeat (3) step_cycle();
        fin_req = 1'b1;
        repeat (5) step_cycle();
        $display("FAIL monitor_finish got=no_summary expected=summary");
        $fatal(1);
    end

endmodule

// File: doc/nested_loop_counter.md
# nested_loop_counter

Parametrised multi-level loop counter for PE address generation; successor to the single-level up/down counter. Each of NUM_LEVELS levels holds a runtime-programmable bound and stride, and the levels advance as a nested loop (level 0 innermost). Each iteration presents per-level indices and an accumulated linear address to the consuming datapath under a valid/stall handshake. A one-cycle done pulse ends the sweep.

## Interface

Parameters:
- DATA_WIDTH, 8, width of each level's index, bound and stride.
- NUM_LEVELS, 3, number of nested loop levels (>=1).
- ADDR_WIDTH, 16, width of the accumulated address output.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low (rst==0 at posedge resets).
- cfg_we  in  1  write the configuration of level cfg_level.
- cfg_level  in  clog2(NUM_LEVELS) (min 1)  target level of the write.
- cfg_bound  in  DATA_WIDTH  iteration count of the level; 0 is treated as 1.
- cfg_stride  in  DATA_WIDTH  address increment per step of the level.
- start  in  1  begin a sweep; sampled only in IDLE.
- stall  in  1  consumer back-pressure; holds the current iteration.
- busy  out  1  high in RUN.
- valid  out  1  current index/addr is a live iteration.
- index  out  NUM_LEVELS*DATA_WIDTH  per-level indices, level k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- addr  out  ADDR_WIDTH  sum of per-level offsets, modulo 2^ADDR_WIDTH.
- done  out  1  one-cycle pulse after the final iteration is accepted.
- last  out  NUM_LEVELS  per-level "at final value" flags. Present only with LOOP_LAST_FLAGS_EN; otherwise driven 0.

## Operation

- Registers per level k:
  - bound[k]: reset value 1.
  - stride[k]: reset value 0.
  - i[k]: reset value 0.
  - off[k]: ADDR_WIDTH bits, reset value 0.
- Configuration write: accepted only in IDLE.
  - cfg_we=1 writes bound/stride of cfg_level.
  - cfg_level >= NUM_LEVELS is ignored.
  - Writes in RUN are ignored.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start=1. All i[k] and off[k] are cleared the same edge.
  - RUN -> IDLE on the accepted final iteration.
  - start in RUN is ignored.
- valid = (state==RUN). busy = valid.
- Acceptance: an iteration is accepted at a posedge where valid=1 and stall=0.
- Advance on acceptance (ripple carry from level 0):
  - Level k steps when k==0, or when every level j<k is at its final value (i[j]==eff_bound[j]-1).
  - A stepping level not at its final value: i[k]+=1, off[k]+=stride[k] (zero-extended, modulo 2^ADDR_WIDTH).
  - A stepping level at its final value wraps: i[k]=0, off[k]=0.
- Final iteration: every level at its final value. Its acceptance clears all i/off, returns to IDLE and asserts done for exactly that next cycle.
- addr is combinational: sum of off[k] modulo 2^ADDR_WIDTH. It is therefore aligned with index.
- eff_bound[k] = (bound[k]==0) ? 1 : bound[k]. Total iterations per sweep = product of eff_bound.
- Outputs in IDLE: index=0, addr=0, valid=0, busy=0.
- Reset (rst=0) from any state, including mid-sweep:
  - Returns to IDLE.
  - Clears i, off and done.
  - Restores bound=1 and stride=0.

## Timing

- Start latency: start sampled at edge N gives valid=1 with index=0, addr=0 during cycle N+1.
- Throughput: one iteration per cycle while stall=0.
- Stall: stall=1 holds index/addr/valid unchanged for every stalled cycle.
- Completion: final iteration accepted at edge M gives done=1, busy=0, valid=0 during cycle M+1.
  - A start during cycle M+1 is honoured, giving valid again in cycle M+2.
- Single-iteration sweep (all bounds 1): valid for 1 cycle (if unstalled), done the cycle after.
- Simultaneous start and cfg_we in IDLE: the config write and the counter clear both take effect that edge. The sweep uses the new config.
- No combinational path from stall or start to any output except through registered state. addr depends only on registers.

## Configuration

- Macro LOOP_LAST_FLAGS_EN.
- Defined: last[k] = valid & (i[k]==eff_bound[k]-1), combinational from registers. Consumers use it for row/tile end markers.
- Undefined: last is tied to 0 and the compare-to-final logic is shared only by the carry chain.
- Defined or not, the port list is identical.

## Test plan

- Basic sweep:
  - Stimulus: bounds {L0=2, L1=3, L2=1}, strides {1, 4, 0}, start, no stall.
  - Required: 6 valid beats. (i1,i0) = 00, 01, 10, 11, 20, 21. addr = 0, 1, 4, 5, 8, 9. done pulse on the 7th cycle after start, then busy=0.
- Stall:
  - Stimulus: same config; stall=1 for 3 cycles on the beat with addr=5.
  - Required: addr=5 held for 4 cycles. Sequence otherwise unchanged. done 3 cycles later than the unstalled run.
- Bound zero and address wrap:
  - Stimulus: L0 bound=0, L1 bound=4 stride=200, ADDR_WIDTH=9.
  - Required: L0 acts as 1. addr = 0, 200, 400, 88 (600 mod 512). 4 beats, then done.
- Ignored inputs in RUN:
  - Stimulus: cfg_we and start asserted mid-sweep.
  - Required: sequence and iteration count unchanged. The new config appears in no later sweep unless rewritten in IDLE.
- Reset mid-sweep:
  - Stimulus: rst=0 for one edge on beat 3.
  - Required: next cycle valid=0, busy=0, done=0, index=0. Bounds read back as 1 (a following start gives 1 beat).
- last flags (macro defined):
  - Stimulus: basic sweep config.
  - Required: last[0] high on beats 2, 4, 6. last[1] high on beats 5–6. last[2] high on all beats. With the macro undefined, last==0 throughout.
